// File: rtl/vend_ctrl_multi.sv
// Multi-product coin vending controller: accumulates credit, vends one-hot
// selections at per-product prices, tracks stock, returns change on vend or cancel.
module vend_ctrl_multi #(
  parameter int N_PROD     = 6,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 3,
  parameter int STOCK_INIT = 5,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {8'd45, 8'd40, 8'd35, 8'd25, 8'd20, 8'd10}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coin_valid,
  input  logic [CREDIT_W-1:0]         coin_value,
  input  logic [N_PROD-1:0]           sel,
  input  logic                        cancel,
  input  logic                        refill,
  output logic [N_PROD-1:0]           led,
  output logic [N_PROD-1:0]           vend,
  output logic                        change_valid,
  output logic [CREDIT_W-1:0]         change,
  output logic [CREDIT_W-1:0]         credit,
  output logic [N_PROD*STOCK_W-1:0]   stock,
  output logic                        coin_reject,
  output logic                        sel_err,
  output logic                        busy
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  localparam logic [STOCK_W-1:0] STOCK_LOAD = STOCK_W'(STOCK_INIT);

  state_t                r_state;
  state_t                w_state_next;
  logic [CREDIT_W-1:0]   r_credit;
  logic [STOCK_W-1:0]    r_stock [N_PROD];
  logic [N_PROD-1:0]     r_vend_sel;
  logic                  r_coin_reject;
  logic                  r_sel_err;

  logic [CREDIT_W-1:0]   w_price [N_PROD];
  logic [N_PROD-1:0]     w_can;
  logic [CREDIT_W-1:0]   w_price_sel;
  logic [CREDIT_W:0]     w_sum;
  logic                  w_active;
  logic                  w_onehot;
  logic                  w_accept;
  logic                  w_sel_bad;
  logic                  w_coin_take;
  logic                  w_coin_rej;
  logic                  w_refill;

  generate
    for (genvar gi = 0; gi < N_PROD; gi++) begin : g_chan
      assign w_price[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
      assign w_can[gi]   = (r_credit >= w_price[gi]) && (r_stock[gi] != '0);
      assign stock[gi*STOCK_W +: STOCK_W] = r_stock[gi];
    end
  endgenerate

  assign w_active = (r_state == S_IDLE) || (r_state == S_CREDIT);
  assign w_onehot = (sel != '0) && ((sel & (sel - N_PROD'(1))) == '0);
  assign w_sum    = {1'b0, r_credit} + {1'b0, coin_value};

  // cancel outranks sel, and either one claims the cycle so a coin alongside is refused
  assign w_accept    = w_active && !cancel && w_onehot && ((sel & w_can) != '0);
  assign w_sel_bad   = w_active && !cancel && (sel != '0) && !w_accept;
  assign w_coin_take = coin_valid && w_active && !cancel && !w_accept && !w_sum[CREDIT_W];
  assign w_coin_rej  = coin_valid && !w_coin_take;
  assign w_refill    = refill && w_active && !w_accept;

  always_comb begin
    w_price_sel = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel[i]) w_price_sel = w_price_sel | w_price[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_CREDIT: begin
        if (cancel) begin
          if (r_state == S_CREDIT) w_state_next = S_CHANGE;
        end else if (w_accept) begin
          w_state_next = S_VEND;
        end else if (w_coin_take && (w_sum[CREDIT_W-1:0] != '0)) begin
          w_state_next = S_CREDIT;
        end
      end
      S_VEND:   w_state_next = (r_credit != '0) ? S_CHANGE : S_IDLE;
      S_CHANGE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    vend         = (r_state == S_VEND) ? r_vend_sel : '0;
    change_valid = (r_state == S_CHANGE);
    change       = (r_state == S_CHANGE) ? r_credit : '0;
    busy         = (r_state == S_VEND) || (r_state == S_CHANGE);
    led          = w_active ? w_can : '0;
    credit       = r_credit;
    coin_reject  = r_coin_reject;
    sel_err      = r_sel_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit      <= '0;
      r_vend_sel    <= '0;
      r_coin_reject <= 1'b0;
      r_sel_err     <= 1'b0;
      for (int i = 0; i < N_PROD; i++) r_stock[i] <= STOCK_LOAD;
    end else begin
      r_coin_reject <= w_coin_rej;
      r_sel_err     <= w_sel_bad;
      if (w_accept) r_vend_sel <= sel;
      if (r_state == S_CHANGE)  r_credit <= '0;
      else if (w_accept)        r_credit <= r_credit - w_price_sel;
      else if (w_coin_take)     r_credit <= w_sum[CREDIT_W-1:0];
      // accept implies the chosen channel is non-empty, so the decrement cannot wrap
      for (int i = 0; i < N_PROD; i++) begin
        if (w_refill)                r_stock[i] <= STOCK_LOAD;
        else if (w_accept && sel[i]) r_stock[i] <= r_stock[i] - STOCK_W'(1);
      end
    end
  end

endmodule
